// File: rtl/command_issue_control_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : command_issue_control_pkg
//  Description : Shared types and constants for the PSL command issue block:
//                FSM state enum, default sizing constants, the arbiter
//                request line, the PSL command interface, and a parity helper.
//  Revision    : 1.0  initial parametrised release
// ============================================================================
package command_issue_control_pkg;

    localparam int c_TAG_DEPTH_DEFAULT    = 32;
    localparam int c_CREDIT_WIDTH_DEFAULT = 8;

    localparam logic [12:0] c_PSL_CMD_TOUCH_I = 13'h0240;
    localparam logic [2:0]  c_PSL_ABT_STRICT  = 3'b000;

    typedef logic [7:0] tag_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } command_issue_state;

    typedef struct packed {
        logic        valid;
        logic [12:0] command;
        logic [63:0] address;
        logic [11:0] size;
        logic [2:0]  abt;
    } CommandBufferLine;

    typedef struct packed {
        logic        valid;
        tag_t        tag;
        logic        tag_parity;
        logic [12:0] command;
        logic        command_parity;
        logic [2:0]  abt;
        logic [63:0] address;
        logic        address_parity;
        logic [11:0] size;
        logic [15:0] context_handle;
    } CommandInterfaceOutput;

    // Zero-extension does not change the parity, so narrower fields are
    // passed in widened to 64 bits.
    function automatic logic f_parity(input logic [63:0] i_data, input logic i_odd);
        return i_odd ? ~(^i_data) : (^i_data);
    endfunction

endpackage
`default_nettype wire

// File: rtl/command_issue_control_tag_free_pool.sv
`default_nettype none
// ============================================================================
//  Module      : command_issue_control_tag_free_pool
//  Description : Busy bitmap of TAG_DEPTH tags with a lowest-free priority
//                encoder and a busy lookup for an arbitrary 8-bit tag.
//  Ports       : i_clk, i_rst_n (async active-low)
//                i_alloc      - mark o_alloc_tag busy at this edge
//                i_free       - mark i_tag free at this edge
//                i_tag        - tag to free / look up
//                o_alloc_tag  - lowest-index free tag
//                o_any_free   - at least one tag is free
//                o_tag_busy   - i_tag is in range and busy
//  Revision    : 1.0  initial release
// ============================================================================
module command_issue_control_tag_free_pool
    import command_issue_control_pkg::*;
#(
    parameter int TAG_DEPTH = c_TAG_DEPTH_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_alloc,
    input  logic i_free,
    input  tag_t i_tag,
    output tag_t o_alloc_tag,
    output logic o_any_free,
    output logic o_tag_busy
);

    logic [TAG_DEPTH-1:0] r_busy;
    logic [255:0]         w_busy_ext;

    // Padding to the full 8-bit tag space makes out-of-range tags read as
    // not busy without a separate range compare.
    assign w_busy_ext = 256'(r_busy);
    assign o_tag_busy = w_busy_ext[i_tag];

    // Scan high to low so the last hit, the lowest index, wins.
    always_comb begin
        o_alloc_tag = '0;
        o_any_free  = 1'b0;
        for (int i = TAG_DEPTH - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                o_alloc_tag = tag_t'(i);
                o_any_free  = 1'b1;
            end
        end
    end

    // A legal free always targets a busy tag, and allocation always targets
    // a free one, so the two never address the same bit in one cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= '0;
        end else begin
            for (int i = 0; i < TAG_DEPTH; i++) begin
                if (i_alloc && (o_alloc_tag == tag_t'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if (i_free && (i_tag == tag_t'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/command_issue_control.sv
`default_nettype none
// ============================================================================
//  Module      : command_issue_control
//  Description : Accepts arbiter commands, allocates PSL tags, tracks PSL
//                command credits and drives the registered PSL command bus
//                with tag/command/address parity.
//  Ports       : clock, rstn (async active-low)
//                enabled_in, croom_in        - enable; credits load on IDLE->RUN
//                command_arbiter_in          - request (valid + payload)
//                command_ready_out           - accept qualifier this cycle
//                response_valid_in/tag_in/tag_parity_in - PSL response
//                command_out                 - registered PSL command
//                outstanding_count_out       - tags in flight
//                tag_error_out, parity_error_out - sticky error flags
//  Options     : RESPONSE_TAG_PARITY_CHECK_EN - check response tag parity and
//                drop responses whose parity mismatches.
//  Revision    : 1.0  initial parametrised release
// ============================================================================
module command_issue_control
    import command_issue_control_pkg::*;
#(
    parameter int TAG_DEPTH    = c_TAG_DEPTH_DEFAULT,
    parameter int CREDIT_WIDTH = c_CREDIT_WIDTH_DEFAULT,
    parameter int ODD_PARITY   = 1
) (
    input  logic                  clock,
    input  logic                  rstn,
    input  logic                  enabled_in,
    input  logic [7:0]            croom_in,
    input  CommandBufferLine      command_arbiter_in,
    output logic                  command_ready_out,
    input  logic                  response_valid_in,
    input  logic [7:0]            response_tag_in,
    input  logic                  response_tag_parity_in,
    output CommandInterfaceOutput command_out,
    output logic [8:0]            outstanding_count_out,
    output logic                  tag_error_out,
    output logic                  parity_error_out
);

    localparam logic [CREDIT_WIDTH-1:0] c_CREDIT_ONE = CREDIT_WIDTH'(1);
    localparam logic                    c_ODD        = (ODD_PARITY != 0);

    command_issue_state      r_state;
    command_issue_state      w_state_next;
    logic [CREDIT_WIDTH-1:0] r_credits;
    logic [8:0]              r_outstanding;
    logic                    r_tag_error;
    CommandInterfaceOutput   r_cmd_out;

    logic w_ready;
    logic w_accept;
    logic w_any_free;
    logic w_tag_busy;
    logic w_resp_parity_ok;
    logic w_resp_legal;
    logic w_resp_illegal;
    logic w_load_credits;
    tag_t w_alloc_tag;

    command_issue_control_tag_free_pool #(
        .TAG_DEPTH (TAG_DEPTH)
    ) u_pool (
        .i_clk       (clock),
        .i_rst_n     (rstn),
        .i_alloc     (w_accept),
        .i_free      (w_resp_legal),
        .i_tag       (response_tag_in),
        .o_alloc_tag (w_alloc_tag),
        .o_any_free  (w_any_free),
        .o_tag_busy  (w_tag_busy)
    );

`ifdef RESPONSE_TAG_PARITY_CHECK_EN
    logic r_parity_error;

    assign w_resp_parity_ok = (response_tag_parity_in == f_parity(64'(response_tag_in), c_ODD));

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            r_parity_error <= 1'b0;
        end else if (response_valid_in && !w_resp_parity_ok) begin
            r_parity_error <= 1'b1;
        end
    end

    assign parity_error_out = r_parity_error;
`else
    logic w_unused_parity;

    assign w_unused_parity  = response_tag_parity_in;
    assign w_resp_parity_ok = 1'b1;
    assign parity_error_out = 1'b0;
`endif

    // A parity-rejected response is neither legal nor a tag error.
    assign w_resp_legal   = response_valid_in && w_resp_parity_ok && w_tag_busy;
    assign w_resp_illegal = response_valid_in && w_resp_parity_ok && !w_tag_busy;
    assign w_accept       = command_arbiter_in.valid && w_ready;
    assign w_load_credits = (r_state == IDLE) && enabled_in;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (enabled_in) w_state_next = RUN;
            RUN:     if (!enabled_in) w_state_next = DRAIN;
            DRAIN: begin
                if (enabled_in) begin
                    w_state_next = RUN;
                end else if (r_outstanding == 9'd0) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_ready = 1'b0;
        if ((r_state == RUN) && (r_credits != '0) && w_any_free) begin
            w_ready = 1'b1;
        end
    end

    // Accept only happens with a nonzero count, so the decrement cannot wrap.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            r_credits <= '0;
        end else if (w_load_credits) begin
            r_credits <= CREDIT_WIDTH'(croom_in);
        end else if (w_accept && !w_resp_legal) begin
            r_credits <= r_credits - c_CREDIT_ONE;
        end else if (!w_accept && w_resp_legal && (r_credits != '1)) begin
            r_credits <= r_credits + c_CREDIT_ONE;
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            r_outstanding <= 9'd0;
        end else if (w_accept && !w_resp_legal) begin
            r_outstanding <= r_outstanding + 9'd1;
        end else if (!w_accept && w_resp_legal) begin
            r_outstanding <= r_outstanding - 9'd1;
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            r_tag_error <= 1'b0;
        end else if (w_resp_illegal) begin
            r_tag_error <= 1'b1;
        end
    end

    // Payload fields hold their last value while valid is low.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            r_cmd_out                <= '0;
            r_cmd_out.command        <= c_PSL_CMD_TOUCH_I;
            r_cmd_out.abt            <= c_PSL_ABT_STRICT;
            r_cmd_out.tag_parity     <= f_parity(64'd0, c_ODD);
            r_cmd_out.command_parity <= f_parity(64'(c_PSL_CMD_TOUCH_I), c_ODD);
            r_cmd_out.address_parity <= f_parity(64'd0, c_ODD);
        end else begin
            r_cmd_out.valid <= w_accept;
            if (w_accept) begin
                r_cmd_out.tag            <= w_alloc_tag;
                r_cmd_out.tag_parity     <= f_parity(64'(w_alloc_tag), c_ODD);
                r_cmd_out.command        <= command_arbiter_in.command;
                r_cmd_out.command_parity <= f_parity(64'(command_arbiter_in.command), c_ODD);
                r_cmd_out.abt            <= command_arbiter_in.abt;
                r_cmd_out.address        <= command_arbiter_in.address;
                r_cmd_out.address_parity <= f_parity(command_arbiter_in.address, c_ODD);
                r_cmd_out.size           <= command_arbiter_in.size;
                r_cmd_out.context_handle <= 16'd0;
            end
        end
    end

    assign command_ready_out     = w_ready;
    assign command_out           = r_cmd_out;
    assign outstanding_count_out = r_outstanding;
    assign tag_error_out         = r_tag_error;

endmodule
`default_nettype wire

// File: tb/tb_command_issue_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_command_issue_control
//  Description : Self-checking bench for command_issue_control with a
//                tag-set / credit-count reference model and directed stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_command_issue_control;
    import command_issue_control_pkg::*;

    localparam int TAG_DEPTH    = 32;
    localparam int CREDIT_WIDTH = 8;
    localparam int ODD_PARITY   = 1;
    localparam int CREDIT_MAX   = (1 << CREDIT_WIDTH) - 1;

    logic                  clock = 1'b0;
    logic                  rstn = 1'b0;
    logic                  enabled_in = 1'b0;
    logic [7:0]            croom_in = 8'd0;
    CommandBufferLine      arb = '0;
    logic                  command_ready_out;
    logic                  response_valid_in = 1'b0;
    logic [7:0]            response_tag_in = 8'd0;
    logic                  response_tag_parity_in = 1'b0;
    CommandInterfaceOutput command_out;
    logic [8:0]            outstanding_count_out;
    logic                  tag_error_out;
    logic                  parity_error_out;

    always #5 clock = ~clock;

    command_issue_control #(
        .TAG_DEPTH    (TAG_DEPTH),
        .CREDIT_WIDTH (CREDIT_WIDTH),
        .ODD_PARITY   (ODD_PARITY)
    ) dut (
        .clock                  (clock),
        .rstn                   (rstn),
        .enabled_in             (enabled_in),
        .croom_in               (croom_in),
        .command_arbiter_in     (arb),
        .command_ready_out      (command_ready_out),
        .response_valid_in      (response_valid_in),
        .response_tag_in        (response_tag_in),
        .response_tag_parity_in (response_tag_parity_in),
        .command_out            (command_out),
        .outstanding_count_out  (outstanding_count_out),
        .tag_error_out          (tag_error_out),
        .parity_error_out       (parity_error_out)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Parity by counting ones.
    function automatic logic par(input logic [63:0] v);
        if (ODD_PARITY != 0) return ($countones(v) % 2 == 0);
        return ($countones(v) % 2 == 1);
    endfunction

    // ---------------- reference model ----------------
    bit                 m_busy [256];
    int                 m_credits;
    command_issue_state m_state;
    bit                 m_terr, m_perr, m_valid;
    logic [7:0]         m_tag;
    logic [12:0]        m_cmd;
    logic [63:0]        m_addr;
    logic [11:0]        m_size;
    logic [2:0]         m_abt;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < TAG_DEPTH; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    function automatic int m_lowest_free();
        for (int i = 0; i < TAG_DEPTH; i++) if (!m_busy[i]) return i;
        return -1;
    endfunction

    function automatic bit m_ready();
        return (m_state == RUN) && (m_credits > 0) && (m_lowest_free() >= 0);
    endfunction

    always @(posedge clock or negedge rstn) begin : b_model
        bit rdy, acc, pok, legal;
        int t, cnt;
        if (!rstn) begin
            for (int i = 0; i < 256; i++) m_busy[i] = 1'b0;
            m_credits = 0; m_state = IDLE; m_terr = 0; m_perr = 0; m_valid = 0;
            m_tag = 0; m_cmd = 13'h0240; m_addr = 0; m_size = 0; m_abt = 0;
        end else begin
            rdy = m_ready();
            t   = m_lowest_free();
            cnt = m_count();
            acc = arb.valid && rdy;
`ifdef RESPONSE_TAG_PARITY_CHECK_EN
            pok = (response_tag_parity_in == par(64'(response_tag_in)));
`else
            pok = 1'b1;
`endif
            legal = response_valid_in && pok && (int'(response_tag_in) < TAG_DEPTH)
                    && m_busy[response_tag_in];
            if (response_valid_in && !pok) m_perr = 1'b1;
            if (response_valid_in && pok && !legal) m_terr = 1'b1;
            if (m_state == IDLE && enabled_in) begin
                m_credits = int'(croom_in);
            end else begin
                m_credits = m_credits - int'(acc) + int'(legal);
                if (m_credits > CREDIT_MAX) m_credits = CREDIT_MAX;
            end
            if (legal) m_busy[response_tag_in] = 1'b0;
            m_valid = acc;
            if (acc) begin
                m_busy[t] = 1'b1;
                m_tag  = 8'(t);
                m_cmd  = arb.command;
                m_addr = arb.address;
                m_size = arb.size;
                m_abt  = arb.abt;
            end
            case (m_state)
                IDLE:    if (enabled_in) m_state = RUN;
                RUN:     if (!enabled_in) m_state = DRAIN;
                default: begin
                    if (enabled_in) m_state = RUN;
                    else if (cnt == 0) m_state = IDLE;
                end
            endcase
        end
    end

    // ---------------- compare + issue log ----------------
    CommandInterfaceOutput issued_q[$];

    always @(negedge clock) begin
        check("ready", 64'(command_ready_out), 64'(m_ready()));
        check("outstanding", 64'(outstanding_count_out), 64'(m_count()));
        check("tag_error", 64'(tag_error_out), 64'(m_terr));
        check("parity_error", 64'(parity_error_out), 64'(m_perr));
        check("credits", 64'(dut.r_credits), 64'(m_credits));
        check("state", 64'(dut.r_state), 64'(m_state));
        check("cmd_valid", 64'(command_out.valid), 64'(m_valid));
        if (m_valid) begin
            check("cmd_tag", 64'(command_out.tag), 64'(m_tag));
            check("cmd_command", 64'(command_out.command), 64'(m_cmd));
            check("cmd_address", command_out.address, m_addr);
            check("cmd_size", 64'(command_out.size), 64'(m_size));
            check("cmd_abt", 64'(command_out.abt), 64'(m_abt));
            check("cmd_ctx", 64'(command_out.context_handle), 64'd0);
            check("cmd_tag_par", 64'(command_out.tag_parity), 64'(par(64'(m_tag))));
            check("cmd_cmd_par", 64'(command_out.command_parity), 64'(par(64'(m_cmd))));
            check("cmd_addr_par", 64'(command_out.address_parity), 64'(par(m_addr)));
        end
        if (command_out.valid) issued_q.push_back(command_out);
    end

    // ---------------- arbiter: holds the queue head until accepted ----------------
    CommandBufferLine cmd_q[$];
    bit hs = 1'b0;

    always @(negedge clock) hs = arb.valid && command_ready_out && rstn;

    always @(posedge clock) begin
        #1;
        if (hs && cmd_q.size() > 0) void'(cmd_q.pop_front());
        hs = 1'b0;
        if (cmd_q.size() > 0) begin
            arb = cmd_q[0];
            arb.valid = 1'b1;
        end else begin
            arb = '0;
        end
    end

    task automatic push_cmd(input logic [12:0] c, input logic [63:0] a, input logic [2:0] abt);
        CommandBufferLine l;
        l = '0;
        l.command = c;
        l.address = a;
        l.size    = 12'd128;
        l.abt     = abt;
        cmd_q.push_back(l);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic respond(input logic [7:0] tag, input bit bad_parity);
        response_valid_in      = 1'b1;
        response_tag_in        = tag;
        response_tag_parity_in = par(64'(tag)) ^ bad_parity;
        tick(1);
        response_valid_in = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        tick(3);
        // Reset values (hand-computed parity: 0x240 has two ones, 0 has none)
        check("rst_ready", 64'(command_ready_out), 64'd0);
        check("rst_outstanding", 64'(outstanding_count_out), 64'd0);
        check("rst_valid", 64'(command_out.valid), 64'd0);
        check("rst_command", 64'(command_out.command), 64'h0240);
        check("rst_abt", 64'(command_out.abt), 64'd0);
        check("rst_tag_par", 64'(command_out.tag_parity), 64'd1);
        check("rst_cmd_par", 64'(command_out.command_parity), 64'd1);
        check("rst_addr_par", 64'(command_out.address_parity), 64'd1);
        rstn = 1'b1;
        tick(1);

        // Six back-to-back commands against four credits
        croom_in   = 8'd4;
        enabled_in = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k == 3) push_cmd(13'h0A00, 64'hFFFF_0000_0000_0001, 3'd1);
            else        push_cmd(13'(13'h0100 + k), 64'(k * 64'h1000), 3'(k % 4));
        end
        tick(10);
        check("A_issued", 64'(issued_q.size()), 64'd4);
        for (int k = 0; k < 4 && k < issued_q.size(); k++)
            check("A_tag", 64'(issued_q[k].tag), 64'(k));
        check("A_ready", 64'(command_ready_out), 64'd0);
        check("A_outstanding", 64'(outstanding_count_out), 64'd4);
        check("A_credits", 64'(dut.r_credits), 64'd0);
        if (issued_q.size() >= 4) begin
            check("A_par_tag3", 64'(issued_q[3].tag_parity), 64'd1);
            check("A_par_cmdA00", 64'(issued_q[3].command_parity), 64'd1);
            check("A_par_addr", 64'(issued_q[3].address_parity), 64'd0);
        end

        // Freed tag 2 is reused by the next command
        respond(8'd2, 1'b0);
        tick(3);
        check("B_issued", 64'(issued_q.size()), 64'd5);
        if (issued_q.size() >= 5) check("B_tag", 64'(issued_q[4].tag), 64'd2);
        check("B_credits", 64'(dut.r_credits), 64'd0);
        check("B_outstanding", 64'(outstanding_count_out), 64'd4);

        // Accept and response for tag 0 in the same cycle
        respond(8'd1, 1'b0);
        respond(8'd0, 1'b0);
        tick(2);
        check("C_issued", 64'(issued_q.size()), 64'd6);
        if (issued_q.size() >= 6) check("C_tag", 64'(issued_q[5].tag), 64'd1);
        check("C_credits", 64'(dut.r_credits), 64'd1);
        check("C_outstanding", 64'(outstanding_count_out), 64'd3);
        check("C_ready", 64'(command_ready_out), 64'd1);

        // Drain with three outstanding
        enabled_in = 1'b0;
        tick(1);
        check("D_ready", 64'(command_ready_out), 64'd0);
        check("D_state", 64'(dut.r_state), 64'(DRAIN));
        respond(8'd1, 1'b0);
        respond(8'd2, 1'b0);
        respond(8'd3, 1'b0);
        tick(3);
        check("D_idle", 64'(dut.r_state), 64'(IDLE));
        check("D_credits", 64'(dut.r_credits), 64'd4);

        // Illegal responses while idle
        check("E_no_err", 64'(tag_error_out), 64'd0);
        respond(8'd7, 1'b0);
        respond(8'd40, 1'b0);
        tick(1);
        check("E_tag_err", 64'(tag_error_out), 64'd1);
        check("E_credits", 64'(dut.r_credits), 64'd4);
        check("E_outstanding", 64'(outstanding_count_out), 64'd0);

        // Re-enable reloads credits
        croom_in   = 8'd8;
        enabled_in = 1'b1;
        tick(2);
        check("F_credits", 64'(dut.r_credits), 64'd8);
        check("F_state", 64'(dut.r_state), 64'(RUN));
        check("F_err_sticky", 64'(tag_error_out), 64'd1);

        // Asynchronous reset mid-operation
        for (int k = 0; k < 3; k++) push_cmd(13'h0200, 64'(k), 3'd2);
        tick(6);
        check("G_outstanding", 64'(outstanding_count_out), 64'd3);
        check("G_credits", 64'(dut.r_credits), 64'd5);
        #2 rstn = 1'b0;
        #1;
        check("G_rst_outstanding", 64'(outstanding_count_out), 64'd0);
        check("G_rst_ready", 64'(command_ready_out), 64'd0);
        check("G_rst_tag_err", 64'(tag_error_out), 64'd0);
        check("G_rst_valid", 64'(command_out.valid), 64'd0);
        check("G_rst_credits", 64'(dut.r_credits), 64'd0);
        croom_in = 8'd40;
        tick(2);
        rstn = 1'b1;

        // Pool exhaustion with credits to spare
        base = issued_q.size();
        for (int k = 0; k < 34; k++) push_cmd(13'h0300, 64'(k * 128), 3'd0);
        tick(40);
        check("H_issued", 64'(issued_q.size() - base), 64'd32);
        check("H_last_tag", 64'(issued_q[issued_q.size() - 1].tag), 64'd31);
        check("H_outstanding", 64'(outstanding_count_out), 64'd32);
        check("H_ready", 64'(command_ready_out), 64'd0);
        check("H_credits", 64'(dut.r_credits), 64'd8);

`ifdef RESPONSE_TAG_PARITY_CHECK_EN
        respond(8'h01, 1'b1);
        tick(2);
        check("I_parity_err", 64'(parity_error_out), 64'd1);
        check("I_outstanding", 64'(outstanding_count_out), 64'd32);
        check("I_credits", 64'(dut.r_credits), 64'd8);
`endif

        respond(8'h01, 1'b0);
        tick(3);
        check("J_last_tag", 64'(issued_q[issued_q.size() - 1].tag), 64'd1);
        check("J_outstanding", 64'(outstanding_count_out), 64'd32);
        check("J_credits", 64'(dut.r_credits), 64'd8);
        check("J_tag_err", 64'(tag_error_out), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/command_issue_control.md
Name: command_issue_control

Overview:
Parametrised successor to the fixed single-pipe command driver. Accepts commands from the command arbiter with a valid/ready handshake and allocates PSL tags from an internal pool of TAG_DEPTH tags. It tracks PSL command credits (croom) and frees tags and credits on PSL responses. It drives the registered PSL command interface with odd parity on tag, command and address. Sits between the command arbiter and the PSL command bus; the response control block feeds it response tags.

Parameters:
TAG_DEPTH, 32, number of allocatable tags, 1..256; tags issued are 0..TAG_DEPTH-1
CREDIT_WIDTH, 8, width of the credit counter; must hold croom_in
ODD_PARITY, 1, 1 = odd parity on command outputs, 0 = even

Ports:
clock  in  1  Clock
rstn  in  1  Asynchronous active-low reset
enabled_in  in  1  Block enable; the rising edge loads credits
croom_in  in  8  PSL command room; sampled on the enable rising edge
command_arbiter_in  in  CommandBufferLine  Arbiter request; valid plus payload (command, address, size, abt)
command_ready_out  out  1  Accept qualifier to the arbiter for the current cycle
response_valid_in  in  1  PSL response strobe
response_tag_in  in  8  Tag of the response
response_tag_parity_in  in  1  Parity of response_tag_in; used only with the optional feature
command_out  out  CommandInterfaceOutput  Registered PSL command interface
outstanding_count_out  out  9  Number of tags currently in flight
tag_error_out  out  1  Sticky flag: response for a tag that is not outstanding
parity_error_out  out  1  Sticky flag: response tag parity mismatch

Behaviour:
- Reset values:
  - command_out all fields 0, except command = TOUCH_I and abt = STRICT; parity bits are computed from those values.
  - command_ready_out 0, outstanding_count_out 0, both error flags 0.
  - Credit counter 0, tag pool all free, FSM in IDLE.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE→RUN when enabled_in = 1. In that transition cycle the credit counter loads croom_in.
  - RUN→DRAIN when enabled_in = 0.
  - DRAIN→IDLE when outstanding = 0.
  - DRAIN→RUN when enabled_in returns to 1. Credits are not reloaded.
- command_ready_out = (state == RUN) && credits != 0 && a free tag exists. It is combinational from registered state only.
- Accept condition: command_arbiter_in.valid && command_ready_out in cycle N.
  - command_out.valid = 1 in cycle N+1, carrying the payload, the allocated tag, context_handle = 0 and the three parity bits.
  - In cycle N+1, command_out.valid = 0 when no accept happened in cycle N.
- Tag allocation: the lowest-index free tag is allocated. The tag is marked busy at the clock edge that ends cycle N.
- Credits:
  - Decrement by 1 per accept.
  - Increment by 1 per valid, legal response.
  - A simultaneous accept and response leaves the count unchanged.
  - The counter saturates at its maximum and never wraps below 0.
- Responses: a legal response frees the tag at the clock edge. The freed tag is allocatable from the next cycle, not in the same cycle.
- Illegal response (tag >= TAG_DEPTH, or tag not busy): sets tag_error_out. Credits and the pool are unchanged.
- outstanding_count_out = popcount of busy tags. It is maintained as a counter: +1 on accept, -1 on legal response, unchanged when both occur together.
- Pool full (TAG_DEPTH outstanding) or credits = 0: ready is deasserted; no command is lost or duplicated.
- Asynchronous reset mid-operation: all state returns to reset values immediately. Outstanding tags are forgotten.
- The error flags are cleared only by reset.

Optional Feature:
RESPONSE_TAG_PARITY_CHECK_EN
- Defined: response_tag_parity_in is checked against the parity of response_tag_in (per ODD_PARITY). On mismatch, parity_error_out sets and the response is ignored: no tag is freed and no credit is returned.
- Undefined: response_tag_parity_in is ignored and parity_error_out is tied to 0.

Decomposition:
- Shared package (AFU_PKG): typedef for the FSM enum (command_issue_state), the TAG_DEPTH default constant and the CREDIT_WIDTH default constant.
- CommandBufferLine and CommandInterfaceOutput stay in their existing packages.
- The existing parity module is reused.
- One natural sub-module: tag_free_pool.
  - Holds a TAG_DEPTH bitmap and a lowest-free priority encoder.
  - Outputs: alloc_tag, any_free, busy lookup.
  - Inputs: alloc strobe, free strobe, free tag.

Test Plan:
- Reset, then raise enable with croom_in = 4 and issue 6 back-to-back commands. Expect tags 0,1,2,3 on command_out at cycles N+1..N+4, then ready = 0 and outstanding = 4.
- Follow with a response for tag 2. Expect ready = 1 the next cycle, the next command issued with tag 2 and credits back at 0.
- Accept and response (tag 0) in the same cycle. Expect credits unchanged, outstanding unchanged, tag 0 not reused in that same cycle.
- Response for tag 7 while idle (not busy), and for tag 40 with TAG_DEPTH = 32. Expect tag_error_out = 1 and credits and outstanding unchanged.
- Drop enable with 3 outstanding. Expect ready = 0 and state DRAIN. After 3 responses, state is IDLE. Re-enable with croom_in = 8 and expect credits = 8.
- With RESPONSE_TAG_PARITY_CHECK_EN, send a response for tag 0x01 with wrong parity. Expect parity_error_out = 1 and tag 1 still busy. Check that command_out parity bits are correct for tag 0x03, command 0x0A00 and address 0xFFFF_0000_0000_0001.
